fpu_op_sequencer: RTL
=====================

# fpu_op_sequencer

The sequencer sits between the FPU top-level request port and the five arithmetic units: add, sub, mul, div and sqrt. It accepts one operation at a time over a valid/ready handshake and registers the operands. It then pulses a start strobe to the selected unit, waits for that unit's done, and returns the result over a valid/ready response port. It replaces free-running per-unit clock selection with explicit start/done sequencing on one common clock, and it flags illegal opcodes and hung units.

## Interface
- `NUM_UNITS`, default 5: number of arithmetic units; opcode N selects unit N.
- `TIMEOUT_CYC`, default 64: maximum number of WAIT cycles before a unit is declared hung.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: sequencer can accept a request.
- `req_op`, input, 3: opcode; 0=add, 1=sub, 2=mul, 3=div, 4=sqrt; 5–7 are illegal.
- `req_a`, input, 32: operand A, IEEE-754 single precision.
- `req_b`, input, 32: operand B; ignored by sqrt.
- `unit_start`, output, NUM_UNITS: one-hot, one-cycle start strobe.
- `unit_a`, output, 32: registered operand A, broadcast to all units.
- `unit_b`, output, 32: registered operand B, broadcast to all units.
- `unit_done`, input, NUM_UNITS: per-unit completion pulse.
- `unit_result`, input, 32*NUM_UNITS: packed results; unit k occupies bits [32k+31:32k].
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_result`, output, 32: result word.
- `rsp_err`, output, 1: response is an error (illegal opcode or timeout).

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, the sequencer latches op/a/b.
  - Legal op: go to ISSUE.
  - Illegal op: go to RESP with `rsp_result`=32'h7FC00000 (qNaN) and `rsp_err`=1. No unit is started.
- **ISSUE**
  - `unit_start[op]`=1 for exactly one cycle; all other start bits are 0.
  - Always go to WAIT.
- **WAIT**
  - `unit_done` is sampled only in this state.
  - On `unit_done[op]`: latch `unit_result[op]` into `rsp_result`, set `rsp_err`=0, go to RESP.
  - Done from a non-selected unit is ignored.
- **RESP**
  - `rsp_valid`=1. `rsp_result` and `rsp_err` are held stable until `rsp_ready`.
  - On `rsp_valid`&&`rsp_ready`, go to IDLE.
- `req_ready`=0 in every state except IDLE, so there is never more than one operation in flight.
- `unit_a`/`unit_b` hold their last latched value until the next accept.
- **Reset value of every output:** `req_ready`=0 while `rst_n`=0 and 1 from the first cycle after release; `unit_start`=0; `unit_a`=0; `unit_b`=0; `rsp_valid`=0; `rsp_result`=0; `rsp_err`=0.
- **Reset mid-operation:** return to IDLE on the next edge, issue no further start, and discard any subsequent done.

## Timing
- Cycle 0: request accepted.
- Cycle 1: ISSUE, start pulse high.
- Cycle 2 onward: WAIT.
- If done arrives in cycle n (n≥2), `rsp_valid` rises in cycle n+1.
- Minimum accept-to-response latency is 3 cycles.
- Illegal opcode: `rsp_valid` in cycle 1.
- Back-to-back: after the response handshake in cycle m, `req_ready`=1 in cycle m+1.
- A done arriving in the ISSUE cycle is not captured. Units must assert done no earlier than one cycle after start.
- A consumer stall (`rsp_ready`=0) holds RESP indefinitely.

## Configuration
- `FPU_SEQ_TIMEOUT_EN` defined:
  - A WAIT-cycle counter resets on WAIT entry.
  - If it reaches `TIMEOUT_CYC` without `unit_done[op]`, go to RESP with `rsp_result`=32'h7FC00000 and `rsp_err`=1.
  - If done and timeout fire in the same cycle, done wins.
- `FPU_SEQ_TIMEOUT_EN` undefined:
  - No counter is built; WAIT waits forever.
  - `rsp_err` is asserted only for illegal opcodes.

## Structure
- Shared package `fpu_pkg` holds:
  - opcode constants `OP_ADD`..`OP_SQRT`;
  - the `seq_state_t` enum;
  - `FP_QNAN`=32'h7FC00000.
- One sub-module, `fpu_seq_timeout`, contains the clear/count/expire counter and is instantiated only under the macro.

## Test plan
- **Add:** op=0, a=32'h3F800000, b=32'h40000000; mock adder returns 32'h40400000 with done 4 cycles after start → `unit_start`=5'b00001 for one cycle, `rsp_result`=32'h40400000, `rsp_err`=0, `rsp_valid` 5 cycles after the start cycle.
- **Illegal opcode:** op=6 → no `unit_start` bit ever set; `rsp_valid` in cycle 1 with 32'h7FC00000 and `rsp_err`=1.
- **Back-pressure and stray done:** sqrt (op=4) with `rsp_ready`=0 for 10 cycles, plus a spurious `unit_done[0]` during WAIT → stray done ignored; result held stable for all 10 cycles; `req_ready`=0 throughout; IDLE one cycle after `rsp_ready`.
- **Timeout (macro on, TIMEOUT_CYC=64):** div unit never asserts done → error response after 64 WAIT cycles. With done and expiry in the same cycle, the unit's result is returned instead.
- **Reset mid-WAIT:** `rst_n`=0 for one cycle during mul → all outputs at reset values; a later `unit_done[2]` produces no response; a new add completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operation sequencer: opcodes, the sequencer
// state encoding and the quiet-NaN pattern used for error responses.
package fpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SQRT = 3'd4;

  // Canonical single-precision quiet NaN returned with every error response.
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_RESP  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fpu_seq_timeout.sv
// WAIT-cycle watchdog for the FPU operation sequencer. Only instantiated when
// FPU_SEQ_TIMEOUT_EN is defined. The counter is cleared while the sequencer is
// about to enter WAIT and counts each WAIT cycle; expired_o is high during the
// TIMEOUT_CYC-th consecutive WAIT cycle.
module fpu_seq_timeout #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int              CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, saturate at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CW{1'b0}};
    end else if (count_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of WAIT cycles already completed.
  assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/fpu_op_sequencer.sv
// FPU operation sequencer: accepts one request at a time, strobes the selected
// arithmetic unit, waits for its done pulse and returns the result on a
// valid/ready response port. Illegal opcodes return a qNaN error response.
// Optional macro FPU_SEQ_TIMEOUT_EN adds a WAIT watchdog that returns a qNaN
// error after TIMEOUT_CYC WAIT cycles (a done in the same cycle wins).
// All outputs are registered and are derived from the next-state values.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int NUM_UNITS   = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [31:0]              req_a,
  input  logic [31:0]              req_b,
  output logic [NUM_UNITS-1:0]     unit_start,
  output logic [31:0]              unit_a,
  output logic [31:0]              unit_b,
  input  logic [NUM_UNITS-1:0]     unit_done,
  input  logic [32*NUM_UNITS-1:0]  unit_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic                     rsp_err
);

  localparam logic [3:0] NUM_UNITS_W = 4'(NUM_UNITS);

  seq_state_t             state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [31:0]            a_q, a_d;
  logic [31:0]            b_q, b_d;
  logic [31:0]            result_q, result_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  logic                   valid_q, valid_d;
  logic [NUM_UNITS-1:0]   start_q, start_d;

  logic                   legal_s;
  logic                   sel_done_s;
  logic [31:0]            sel_result_s;
  logic                   timeout_s;

  assign legal_s = ({1'b0, req_op} < NUM_UNITS_W);

`ifdef FPU_SEQ_TIMEOUT_EN
  fpu_seq_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == SEQ_ISSUE),
    .count_i   (state_q == SEQ_WAIT),
    .expired_o (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Select done and result of the unit addressed by the latched opcode.
  always_comb begin
    sel_done_s   = 1'b0;
    sel_result_s = 32'h0000_0000;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (op_q == 3'(k)) begin
        sel_done_s   = unit_done[k];
        sel_result_s = unit_result[32*k +: 32];
      end else begin
        sel_done_s   = sel_done_s;
        sel_result_s = sel_result_s;
      end
    end
  end

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      SEQ_IDLE: begin
        if (req_valid && ready_q) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          if (legal_s) begin
            state_d = SEQ_ISSUE;
          end else begin
            state_d  = SEQ_RESP;
            result_d = FP_QNAN;
            err_d    = 1'b1;
          end
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_ISSUE: begin
        // Any done seen here is deliberately not captured.
        state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (sel_done_s) begin
          state_d  = SEQ_RESP;
          result_d = sel_result_s;
          err_d    = 1'b0;
        end else if (timeout_s) begin
          state_d  = SEQ_RESP;
          result_d = FP_QNAN;
          err_d    = 1'b1;
        end else begin
          state_d = SEQ_WAIT;
        end
      end
      SEQ_RESP: begin
        if (rsp_ready) begin
          state_d = SEQ_IDLE;
        end else begin
          state_d = SEQ_RESP;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    ready_d = (state_d == SEQ_IDLE);
    valid_d = (state_d == SEQ_RESP);
    start_d = {NUM_UNITS{1'b0}};
    for (int k = 0; k < NUM_UNITS; k++) begin
      start_d[k] = (state_d == SEQ_ISSUE) && (op_d == 3'(k));
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SEQ_IDLE;
      op_q     <= 3'd0;
      a_q      <= 32'h0000_0000;
      b_q      <= 32'h0000_0000;
      result_q <= 32'h0000_0000;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      start_q  <= {NUM_UNITS{1'b0}};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
    end
  end

  assign req_ready  = ready_q;
  assign unit_start = start_q;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign rsp_valid  = valid_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;

endmodule
